// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the instruction memory and presents the fetched word to
// decode over a valid/ready handshake, with stall, redirect/flush and a sticky PC fault.
module instruction_fetch #(
  parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned  MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        pc_ld,
  input  logic [31:0] pc_target,
  input  logic [31:0] im_dout,
  output logic [31:0] im_addr,
  output logic        im_cs,
  output logic        im_rd,
  output logic        im_wr,
  output logic [31:0] im_din,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] ir_pc4,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        fault
);

  localparam int unsigned W      = 32;
  localparam logic [W-1:0] PC_MAX = W'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] pc, pc_nxt;
  logic [W-1:0] ir_nxt, ir_pc_nxt, ir_pc4_nxt;
  logic         ir_valid_nxt, fault_nxt, sel, sel_nxt;
  logic         advance;

  // Misaligned or beyond the last full word of memory.
  function automatic logic illegal_pc(input logic [W-1:0] a);
    return (a[1:0] != 2'b00) || (a > PC_MAX);
  endfunction

  assign im_addr = pc;
  assign im_cs   = sel;
  assign im_rd   = sel;
  assign im_wr   = 1'b0;
  assign im_din  = '0;
  assign advance = !stall && (!ir_valid || ir_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_pc4   <= '0;
      ir_valid <= 1'b0;
      fault    <= 1'b0;
      sel      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      ir       <= ir_nxt;
      ir_pc    <= ir_pc_nxt;
      ir_pc4   <= ir_pc4_nxt;
      ir_valid <= ir_valid_nxt;
      fault    <= fault_nxt;
      sel      <= sel_nxt;
    end
  end

  // Next-state and datapath update; RUN rules are checked in priority order.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    ir_pc_nxt    = ir_pc;
    ir_pc4_nxt   = ir_pc4;
    ir_valid_nxt = ir_valid;
    fault_nxt    = fault;

    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (pc_ld) begin
          // Target loads even when illegal so the faulting address is visible.
          pc_nxt       = pc_target;
          ir_valid_nxt = 1'b0;
          if (illegal_pc(pc_target)) state_nxt = FAULT;
        end else if (illegal_pc(pc)) begin
          state_nxt = FAULT;
        end else if (advance) begin
          ir_nxt       = im_dout;
          ir_pc_nxt    = pc;
          ir_pc4_nxt   = W'(pc + W'(4));
          ir_valid_nxt = 1'b1;
          pc_nxt       = W'(pc + W'(4));
        end else if (ir_valid && ir_ready) begin
          ir_valid_nxt = 1'b0;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase

    if (state_nxt == FAULT) begin
      ir_valid_nxt = 1'b0;
      fault_nxt    = 1'b1;
    end
    sel_nxt = (state_nxt == RUN);
  end

endmodule
